// File: rtl/softmax_pkg.sv
// Shared softmax definitions: FSM states and exp-ROM index geometry.
package softmax_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      EMIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int IDX_W   = 4;
   localparam int IDX_MAX = 15;
   localparam int ROM_LAT = 1;

endpackage

// File: rtl/softmax_index_gen_if.sv
// Sample stream in, exp-ROM address and result qualifiers out.
interface softmax_index_gen_if
   import softmax_pkg::*;
#(
   parameter int DATA_W = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic [IDX_W-1:0]         rom_idx;
   logic                     rom_idx_valid;
   logic                     out_valid;
   logic                     out_last;
   logic                     busy;

   // Upstream source / observer side.
   modport master (
      output in_valid, in_data,
      input  in_ready, rom_idx, rom_idx_valid, out_valid, out_last, busy
   );

   // Index generator side.
   modport slave (
      input  in_valid, in_data,
      output in_ready, rom_idx, rom_idx_valid, out_valid, out_last, busy
   );
endinterface

// File: rtl/softmax_idx_sat.sv
// (max - x) >> SHIFT saturated to a 4-bit exp-ROM index. Pure combinational.
module softmax_idx_sat
   import softmax_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SHIFT  = 2
) (
   input  logic signed [DATA_W-1:0] max_val,
   input  logic signed [DATA_W-1:0] x_val,
   output logic [IDX_W-1:0]         idx
);
   // One extra bit so max - x never wraps; max >= x keeps the result non-negative.
   logic [DATA_W:0] diff;
   logic [DATA_W:0] shifted;

   assign diff    = {max_val[DATA_W-1], max_val} - {x_val[DATA_W-1], x_val};
   assign shifted = diff >> SHIFT;
   assign idx     = (shifted > (DATA_W+1)'(IDX_MAX)) ? IDX_W'(IDX_MAX)
                                                      : shifted[IDX_W-1:0];
endmodule

// File: rtl/softmax_index_gen.sv
// Buffers a vector while tracking its max, then replays it as exp-ROM indices
// with out_valid/out_last timed to the ROM's registered result.
module softmax_index_gen
   import softmax_pkg::*;
#(
   parameter int VEC_LEN = 16,
   parameter int DATA_W  = 8,
   parameter int SHIFT   = 2
) (
   input logic                clk,
   input logic                rst_n,
   softmax_index_gen_if.slave bus
);
   localparam int                       CNT_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(VEC_LEN - 1);
   localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic signed [DATA_W-1:0] max_r;
   logic signed [DATA_W-1:0] sample_buf [VEC_LEN];
   logic                     out_valid_r;
   logic                     out_last_r;
   logic [IDX_W-1:0]         sat_idx;
   logic                     accept;

   assign accept = (state == LOAD) && bus.in_valid;

   // Sample buffer: contents are don't-care after reset, so no reset term.
   always_ff @(posedge clk) begin
      if (accept) sample_buf[cnt] <= bus.in_data;
   end

   // Control FSM; out_valid/out_last trail EMIT by the ROM's one-cycle latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= LOAD;
         cnt         <= '0;
         max_r       <= DATA_MIN;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         out_valid_r <= (state == EMIT);
         out_last_r  <= (state == EMIT) && (cnt == CNT_LAST);
         case (state)
            LOAD: begin
               if (bus.in_valid) begin
                  if (bus.in_data > max_r) max_r <= bus.in_data;
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= EMIT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            EMIT: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               // Re-arm the running max for the next vector.
               max_r <= DATA_MIN;
               state <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

   softmax_idx_sat #(
      .DATA_W (DATA_W),
      .SHIFT  (SHIFT)
   ) u_sat (
      .max_val (max_r),
      .x_val   (sample_buf[cnt]),
      .idx     (sat_idx)
   );

   assign bus.in_ready      = (state == LOAD);
   assign bus.rom_idx_valid = (state == EMIT);
   assign bus.rom_idx       = (state == EMIT) ? sat_idx : '0;
   assign bus.out_valid     = out_valid_r;
   assign bus.out_last      = out_last_r;
   assign bus.busy          = (state != LOAD);

endmodule

// File: tb/tb_softmax_index_gen.sv
// Scoreboard bench: two DUTs (SHIFT=2 and SHIFT=0) fed the same sample stream.
module tb_softmax_index_gen;
   import softmax_pkg::*;

   localparam int ASC = 0, NEG = 1, EDGE = 2, MIX = 3, M1 = 4;

   typedef struct {
      logic [3:0] idx;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   rv_rise_cyc = -1;

   exp_t q2[$];
   exp_t q0[$];

   logic signed [7:0] vecs [5][16];
   logic [3:0]        exp2 [5][16];
   logic [3:0]        exp0 [5][16];

   softmax_index_gen_if #(.DATA_W(8)) bus  ();
   softmax_index_gen_if #(.DATA_W(8)) bus0 ();

   assign bus0.in_valid = bus.in_valid;
   assign bus0.in_data  = bus.in_data;

   softmax_index_gen #(.VEC_LEN(16), .DATA_W(8), .SHIFT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   softmax_index_gen #(.VEC_LEN(16), .DATA_W(8), .SHIFT(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset();
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_rom_idx", bus.rom_idx, 0);
      check("rst_rom_idx_valid", bus.rom_idx_valid, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_out_valid_s0", bus0.out_valid, 0);
   endtask

   // Offer one sample, wait for acceptance, return the accept edge number.
   task automatic push_sample(input logic signed [7:0] d, output int acc_cyc);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_vec(input int vi, input bit gaps, output int first_acc, output int last_acc);
      int acc;
      for (int k = 0; k < 16; k++) begin
         q2.push_back('{idx: exp2[vi][k], last: (k == 15)});
         q0.push_back('{idx: exp0[vi][k], last: (k == 15)});
      end
      first_acc = 0;
      acc       = 0;
      for (int k = 0; k < 16; k++) begin
         push_sample(vecs[vi][k], acc);
         if (k == 0) first_acc = acc;
         if (gaps && k < 15) repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
      end
      last_acc = acc;
      @(negedge clk); #1;
      check("first_idx_latency", rv_rise_cyc, last_acc);
   endtask

   // Monitor for the SHIFT=2 instance.
   initial begin
      exp_t e;
      logic ov_exp = 1'b0, last_exp = 1'b0, prev_rv = 1'b0;
      int   lowrun = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ov_exp = 1'b0; last_exp = 1'b0; prev_rv = 1'b0; lowrun = 0;
         end else begin
            check("out_valid_s2", bus.out_valid, ov_exp);
            check("out_last_s2", bus.out_last, last_exp);
            ov_exp = 1'b0; last_exp = 1'b0;
            if (bus.rom_idx_valid) begin
               if (!prev_rv) rv_rise_cyc = cyc;
               check("busy_in_emit", bus.busy, 1);
               if (q2.size() == 0) check("unexpected_idx_s2", 1, 0);
               else begin
                  e = q2.pop_front();
                  check("rom_idx_s2", bus.rom_idx, e.idx);
                  ov_exp = 1'b1; last_exp = e.last;
               end
            end else begin
               check("rom_idx_idle_s2", bus.rom_idx, 0);
            end
            prev_rv = bus.rom_idx_valid;
            if (!bus.in_ready) lowrun++;
            else if (lowrun > 0) begin
               check("in_ready_low_cycles", lowrun, 17);
               lowrun = 0;
            end
         end
      end
   end

   // Monitor for the SHIFT=0 instance.
   initial begin
      exp_t e;
      logic ov_exp = 1'b0, last_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ov_exp = 1'b0; last_exp = 1'b0;
         end else begin
            check("out_valid_s0", bus0.out_valid, ov_exp);
            check("out_last_s0", bus0.out_last, last_exp);
            ov_exp = 1'b0; last_exp = 1'b0;
            if (bus0.rom_idx_valid) begin
               if (q0.size() == 0) check("unexpected_idx_s0", 1, 0);
               else begin
                  e = q0.pop_front();
                  check("rom_idx_s0", bus0.rom_idx, e.idx);
                  ov_exp = 1'b1; last_exp = e.last;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      int f1, l1, f2, l2, n;

      for (int k = 0; k < 16; k++) begin
         vecs[ASC][k]  = 8'(k);
         vecs[NEG][k]  = -8'sd128;
         vecs[EDGE][k] = 8'sd0;
         vecs[M1][k]   = -8'sd1;
         exp2[NEG][k]  = 4'd0;
         exp0[NEG][k]  = 4'd0;
         exp2[EDGE][k] = 4'd15;
         exp0[EDGE][k] = 4'd15;
         exp2[M1][k]   = 4'd0;
         exp0[M1][k]   = 4'd0;
      end
      vecs[EDGE][0] = 8'sd127;
      vecs[EDGE][1] = -8'sd128;
      exp2[EDGE][0] = 4'd0;
      exp0[EDGE][0] = 4'd0;
      exp2[ASC] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2,
                    4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
      exp0[ASC] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
                    4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      vecs[MIX] = '{8'sd5, 8'sd3, 8'sd5, -8'sd20, 8'sd4, 8'sd1, 8'sd0, -8'sd3,
                    8'sd5, 8'sd2, -8'sd10, 8'sd3, 8'sd4, -8'sd11, 8'sd5, -8'sd128};
      exp0[MIX] = '{4'd0, 4'd2, 4'd0, 4'd15, 4'd1, 4'd4, 4'd5, 4'd8,
                    4'd0, 4'd3, 4'd15, 4'd2, 4'd1, 4'd15, 4'd0, 4'd15};
      exp2[MIX] = '{4'd0, 4'd0, 4'd0, 4'd6, 4'd0, 4'd1, 4'd1, 4'd2,
                    4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd4, 4'd0, 4'd15};

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #3;
      check_reset();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      send_vec(ASC,  1'b0, f1, l1);
      send_vec(NEG,  1'b0, f1, l1);
      send_vec(EDGE, 1'b0, f1, l1);
      send_vec(MIX,  1'b0, f1, l1);
      send_vec(ASC,  1'b1, f1, l1);

      // Reset in EMIT once five elements have been presented.
      send_vec(ASC, 1'b0, f1, l1);
      n = 0;
      while (q2.size() > 11 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("reset_point_reached", q2.size(), 11);
      rst_n = 1'b0;
      #1;
      check_reset();
      q2.delete();
      q0.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      send_vec(MIX, 1'b0, f1, l1);

      // Back-to-back with in_valid held; second vector needs a re-armed max.
      send_vec(ASC, 1'b0, f1, l1);
      send_vec(M1,  1'b0, f2, l2);
      check("b2b_idle_gap", f2 - l1 - 1, 17);

      n = 0;
      while ((q2.size() != 0 || q0.size() != 0) && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      repeat (3) @(negedge clk);
      check("q2_drained", q2.size(), 0);
      check("q0_drained", q0.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
